miner_soln_fifo: RTL and testbench
==================================

MINER_SOLN_FIFO -- requirements
Module: miner_soln_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, solution FIFO entries (power of 2, 2..16).
REQ-002 SHALL have port clk  in  1  single clock shared by all logic.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port found  in  1  core "found" status level, asynchronous to clk.
REQ-005 SHALL have port solution  in  64  core solution nonce, stable while found is high.
REQ-006 SHALL have port address  in  3  Avalon-MM word address.
REQ-007 SHALL have port read  in  1  Avalon read strobe.
REQ-008 SHALL have port write  in  1  Avalon write strobe.
REQ-009 SHALL have port writedata  in  32  Avalon write data.
REQ-010 SHALL have port readdata  out  32  Avalon read data, registered.
REQ-011 SHALL have port irq  out  1  active-high interrupt, FIFO non-empty.

Function
REQ-012 SHALL pass found through a 2-flop synchronizer; a rising edge (sync history 01) is a push request.
REQ-013 SHALL capture solution into the FIFO tail in the push-request cycle.
REQ-014 SHALL decode the register map: 0 head solution[31:0]; 1 head solution[63:32] (pop); 2 STAT; 3 CTL; 4 timestamp; 5-7 read 0.
REQ-015 SHALL update readdata one clock after a read strobe; no wait states.
REQ-016 SHALL pop the head entry on a read of address 1 when non-empty; a read when empty returns 0 and does not pop.
REQ-017 SHALL report STAT = {count[4:0] at [4:0], empty at 5, full at 6, overflow at 7, DEPTH at [15:8], zeros above}.
REQ-018 SHALL make CTL bits: 0 flush (self-clearing), 1 clear overflow (self-clearing), 2 irq_en (reset 0); CTL reads return irq_en only at bit 2.
REQ-019 SHALL, on push with pop in the same cycle, perform both; count is unchanged, also when full.
REQ-020 SHALL, on push when full and no pop, drop the entry and set sticky overflow.
REQ-021 SHALL, on flush, empty the FIFO (count 0, pointers 0); a push in the same cycle is dropped without setting overflow.
REQ-022 SHALL, on clear-overflow together with a new overflow in the same cycle, leave overflow set.
REQ-023 SHALL wrap read/write pointers modulo DEPTH; count ranges 0..DEPTH.
REQ-024 SHALL drive irq registered as irq_en AND NOT empty, one cycle after the state change.
REQ-025 SHALL ignore writes to addresses other than 3.

Reset
REQ-026 SHALL on rst_n low asynchronously clear: sync flops, pointers, count, overflow, irq_en, irq, readdata, timestamp counter.
REQ-027 SHALL treat reset mid-operation as full discard of stored solutions; the first found edge after release is captured normally.

Configuration
REQ-028 SHALL, with MINER_SOLN_TIMESTAMP_EN defined, hold a free-running 32-bit clk counter (wraps at 2^32), store its value with each push, and return the head timestamp at address 4.
REQ-029 SHALL, without MINER_SOLN_TIMESTAMP_EN, omit counter and timestamp storage (64-bit entries); address 4 reads 0.

Structure
REQ-030 SHALL take register indices, STAT/CTL bit positions and the entry width from shared package miner_soln_pkg.
REQ-031 SHALL implement synchronizer plus edge detect as sub-module miner_sync_edge.

Verification
REQ-032 SHALL cover: found pulse with solution 0x0123456789ABCDEF -> STAT count 1, read addr 0 = 0x89ABCDEF, addr 1 = 0x01234567, then count 0, empty 1.
REQ-033 SHALL cover: DEPTH=8, 9 found edges, no reads -> count 8, full 1, overflow 1, ninth solution absent; CTL write 0x2 clears overflow.
REQ-034 SHALL cover: push coincident with pop of addr 1 while full -> count stays 8, overflow 0, new entry at tail.
REQ-035 SHALL cover: CTL=0x4 then one push -> irq high; pop that entry -> irq low next cycle; CTL write 0x1 while 3 entries -> count 0.
REQ-036 SHALL cover: rst_n low for 1 cycle with 5 entries -> count 0, irq 0, readdata 0; with MINER_SOLN_TIMESTAMP_EN, push at counter 100 -> addr 4 reads 100.

Source files
------------

// File: rtl/miner_soln_pkg.sv
// Shared definitions for the miner solution FIFO: register map, STAT/CTL
// bit positions, FIFO entry width and a helper that assembles STAT.
// Build option: MINER_SOLN_TIMESTAMP_EN widens each entry by a 32-bit timestamp.
package miner_soln_pkg;

    // Avalon word addresses; every encoding is named so casts stay in range
    typedef enum logic [2:0] {
        REG_SOL_LO = 3'd0,
        REG_SOL_HI = 3'd1,
        REG_STAT   = 3'd2,
        REG_CTL    = 3'd3,
        REG_TS     = 3'd4,
        REG_RSVD5  = 3'd5,
        REG_RSVD6  = 3'd6,
        REG_RSVD7  = 3'd7
    } reg_addr_e;

    localparam int SOL_W = 64;
    localparam int TS_W  = 32;
    localparam int CNT_W = 5;

`ifdef MINER_SOLN_TIMESTAMP_EN
    localparam int ENTRY_W = SOL_W + TS_W;
`else
    localparam int ENTRY_W = SOL_W;
`endif

    localparam int STAT_CNT_LSB   = 0;
    localparam int STAT_EMPTY_BIT = 5;
    localparam int STAT_FULL_BIT  = 6;
    localparam int STAT_OVF_BIT   = 7;
    localparam int STAT_DEPTH_LSB = 8;

    localparam int CTL_FLUSH_BIT  = 0;
    localparam int CTL_CLROVF_BIT = 1;
    localparam int CTL_IRQEN_BIT  = 2;
    localparam int CTL_W          = 3;

    function automatic logic [31:0] packStat(
        input logic [CNT_W-1:0] count,
        input logic             empty,
        input logic             full,
        input logic             overflow,
        input logic [7:0]       depth
    );
        logic [31:0] stat;
        stat                          = '0;
        stat[STAT_CNT_LSB +: CNT_W]   = count;
        stat[STAT_EMPTY_BIT]          = empty;
        stat[STAT_FULL_BIT]           = full;
        stat[STAT_OVF_BIT]            = overflow;
        stat[STAT_DEPTH_LSB +: 8]     = depth;
        return stat;
    endfunction

endpackage

// File: rtl/miner_sync_edge.sv
// Two-flop synchronizer for the core's asynchronous "found" level, followed
// by a history flop; o_rise is high for one clock on each synchronized 0->1.
module miner_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain plus one cycle of history for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/miner_soln_fifo.sv
// Solution FIFO between a mining core and an Avalon-MM host. Found edges push
// the core's nonce; the host pops by reading the upper word of the head.
// Build option: MINER_SOLN_TIMESTAMP_EN adds a free-running cycle counter whose
// value is stored with each entry and readable at the timestamp address.
module miner_soln_fifo
    import miner_soln_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        found,
    input  logic [63:0] solution,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                 w_push;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_ctlWrite;
    logic                 w_flush;
    logic                 w_clrOvf;
    logic                 w_pop;
    logic                 w_pushOk;
    logic                 w_ovfSet;
    logic [ENTRY_W-1:0]   w_entry;
    logic [ENTRY_W-1:0]   w_head;
    logic [31:0]          w_stat;
    logic [31:0]          w_tsRead;
    logic                 w_unusedBits;

    logic [ENTRY_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wrPtr;
    logic [PTR_W-1:0]     r_rdPtr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_overflow;
    logic                 r_irqEn;
    logic                 r_irq;
    logic [31:0]          r_readdata;

    miner_sync_edge u_syncEdge (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_async (found),
        .o_rise  (w_push)
    );

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_ctlWrite = write && (address == REG_CTL);
    assign w_flush    = w_ctlWrite && writedata[CTL_FLUSH_BIT];
    assign w_clrOvf   = w_ctlWrite && writedata[CTL_CLROVF_BIT];
    assign w_pop      = read && (address == REG_SOL_HI) && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_pushOk   = w_push && !w_flush && (!w_full || w_pop);
    assign w_ovfSet   = w_push && !w_flush && w_full && !w_pop;
    assign w_head     = r_mem[r_rdPtr];
    assign w_stat     = packStat(r_count, w_empty, w_full, r_overflow, 8'(DEPTH));
    assign w_unusedBits = ^writedata[31:CTL_W];

`ifdef MINER_SOLN_TIMESTAMP_EN
    logic [TS_W-1:0] r_tsCnt;

    // Free-running cycle counter, wraps naturally at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tsCnt <= '0;
        end else begin
            r_tsCnt <= r_tsCnt + 1'b1;
        end
    end

    assign w_entry  = {r_tsCnt, solution};
    assign w_tsRead = w_empty ? 32'h0 : w_head[SOL_W +: TS_W];
`else
    assign w_entry  = solution;
    assign w_tsRead = 32'h0;
`endif

    // Entry storage carries no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        if (w_pushOk) begin
            r_mem[r_wrPtr] <= w_entry;
        end
    end

    // Pointers and occupancy; flush overrides any push or pop this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_pushOk) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_pushOk, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow and irq enable; a new overflow beats a clear request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_irqEn    <= 1'b0;
        end else begin
            r_overflow <= w_ovfSet || (r_overflow && !w_clrOvf);
            if (w_ctlWrite) begin
                r_irqEn <= writedata[CTL_IRQEN_BIT];
            end
        end
    end

    // Interrupt follows registered state with one cycle of delay
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_irqEn && !w_empty;
        end
    end

    // Registered read mux; data of an empty FIFO reads as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_readdata <= '0;
        end else if (read) begin
            case (address)
                REG_SOL_LO: r_readdata <= w_empty ? 32'h0 : w_head[31:0];
                REG_SOL_HI: r_readdata <= w_empty ? 32'h0 : w_head[63:32];
                REG_STAT:   r_readdata <= w_stat;
                REG_CTL:    r_readdata <= {29'h0, r_irqEn, 2'b00};
                REG_TS:     r_readdata <= w_tsRead;
                default:    r_readdata <= 32'h0;
            endcase
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule

// File: tb/tb_miner_soln_fifo.sv
// Self-checking bench for miner_soln_fifo: a queue scoreboard holds the
// solutions expected in the FIFO and is compared as the host pops them.
// Build option: MINER_SOLN_TIMESTAMP_EN enables the timestamp scenario.
module tb_miner_soln_fifo;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst_n;
    logic        found;
    logic [63:0] solution;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int checkCount;
    int errorCount;
    int tbCycles;

    logic [95:0] sb[$];
    logic        modelOvf;
    logic        modelIrqEn;
    logic [31:0] rd;

    miner_soln_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .found     (found),
        .solution  (solution),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference cycle counter used to predict stored timestamps
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tbCycles <= 0;
        else        tbCycles <= tbCycles + 1;
    end

    // Hard stop in case something stalls the main sequence
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] expStat();
        logic [31:0] s;
        s = 32'h0;
        s[4:0]  = 5'(sb.size());
        s[5]    = (sb.size() == 0);
        s[6]    = (sb.size() == DEPTH);
        s[7]    = modelOvf;
        s[15:8] = 8'(DEPTH);
        return s;
    endfunction

    task automatic busWrite(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        address = addr; writedata = data; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
        if (addr == 3'd3) begin
            if (data[0]) sb.delete();
            if (data[1]) modelOvf = 1'b0;
            modelIrqEn = data[2];
        end
    endtask

    task automatic busRead(input logic [2:0] addr, output logic [31:0] data);
        @(negedge clk);
        address = addr; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        data = readdata;
    endtask

    // Raise found long enough to pass the synchronizer, then release it
    task automatic applyStimulus(input logic [63:0] value);
        logic [31:0] ts;
        @(negedge clk);
        solution = value; found = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ts = 32'(tbCycles);
        @(negedge clk);
        found = 1'b0;
        repeat (3) @(negedge clk);
        if (sb.size() == DEPTH) modelOvf = 1'b1;
        else sb.push_back({ts, value});
    endtask

    // Push whose request cycle coincides with a pop of the upper head word
    task automatic pushWithPop(input logic [63:0] value);
        logic [31:0] ts;
        logic [95:0] head;
        @(negedge clk);
        solution = value; found = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ts = 32'(tbCycles);
        address = 3'd1; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        head = sb.pop_front();
        checkOutput("coincidentPopHi", readdata, head[63:32]);
        found = 1'b0;
        repeat (3) @(negedge clk);
        sb.push_back({ts, value});
    endtask

    task automatic checkStat(input string tag);
        logic [31:0] d;
        busRead(3'd2, d);
        checkOutput(tag, d, expStat());
    endtask

    task automatic popEntry(input string tag);
        logic [31:0] d;
        logic [95:0] head;
        head = (sb.size() != 0) ? sb[0] : 96'h0;
`ifdef MINER_SOLN_TIMESTAMP_EN
        busRead(3'd4, d);
        checkOutput({tag, "Ts"}, d, head[95:64]);
`endif
        busRead(3'd0, d);
        checkOutput({tag, "Lo"}, d, head[31:0]);
        busRead(3'd1, d);
        checkOutput({tag, "Hi"}, d, head[63:32]);
        if (sb.size() != 0) void'(sb.pop_front());
    endtask

    initial begin
        checkCount = 0; errorCount = 0;
        modelOvf = 1'b0; modelIrqEn = 1'b0;
        rst_n = 1'b0; found = 1'b0; solution = '0;
        address = '0; read = 1'b0; write = 1'b0; writedata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        checkOutput("resetReaddata", readdata, 32'h0);
        checkOutput("resetIrq", {31'h0, irq}, 32'h0);
        checkStat("resetStat");

        // Single solution round trip
        applyStimulus(64'h0123456789ABCDEF);
        checkStat("statOne");
        busRead(3'd0, rd);
        checkOutput("singleLo", rd, 32'h89ABCDEF);
        busRead(3'd1, rd);
        checkOutput("singleHi", rd, 32'h01234567);
        void'(sb.pop_front());
        checkStat("statAfterPop");

        // Empty reads, reserved address, ignored non-CTL write
        busRead(3'd1, rd);
        checkOutput("emptyPopHi", rd, 32'h0);
        checkStat("statEmptyPop");
        busRead(3'd6, rd);
        checkOutput("reservedAddr", rd, 32'h0);
        busRead(3'd4, rd);
        checkOutput("tsEmpty", rd, 32'h0);
        busWrite(3'd2, 32'h7);
        busRead(3'd3, rd);
        checkOutput("ctlAfterBadWrite", rd, 32'h0);

        // Fill past capacity
        for (int i = 0; i < 9; i++) begin
            applyStimulus({32'hA000_0000 + 32'(i), 32'h5000_0000 + 32'(i)});
        end
        checkStat("statOverflow");
        busWrite(3'd3, 32'h2);
        checkStat("statOvfCleared");

        // Push and pop in the same cycle while full
        pushWithPop(64'hFEED_FACE_CAFE_BEEF);
        checkStat("statCoincident");
        for (int i = 0; i < DEPTH; i++) popEntry("drain");
        checkStat("statDrained");

        // Interrupt enable and timing
        busWrite(3'd3, 32'h4);
        busRead(3'd3, rd);
        checkOutput("ctlIrqEn", rd, 32'h4);
        applyStimulus(64'h1111_2222_3333_4444);
        checkOutput("irqHigh", {31'h0, irq}, 32'h1);
        busRead(3'd0, rd);
        checkOutput("irqPopLo", rd, 32'h33334444);
        busRead(3'd1, rd);
        checkOutput("irqPopHi", rd, 32'h11112222);
        void'(sb.pop_front());
        checkOutput("irqStillHigh", {31'h0, irq}, 32'h1);
        @(negedge clk);
        checkOutput("irqLow", {31'h0, irq}, 32'h0);

        // Flush with three entries
        for (int i = 0; i < 3; i++) applyStimulus(64'h7700_0000_0000_0000 + 64'(i));
        checkStat("statThree");
        busWrite(3'd3, 32'h1);
        checkStat("statFlushed");

        // Reset in the middle of operation
        busWrite(3'd3, 32'h4);
        for (int i = 0; i < 5; i++) applyStimulus(64'h5500_0000_0000_0000 + 64'(i));
        checkStat("statFive");
        checkOutput("irqBeforeReset", {31'h0, irq}, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete(); modelOvf = 1'b0; modelIrqEn = 1'b0;
        checkOutput("midResetReaddata", readdata, 32'h0);
        checkOutput("midResetIrq", {31'h0, irq}, 32'h0);
        checkStat("statAfterReset");
        applyStimulus(64'hDEAD_BEEF_0BAD_F00D);
        checkStat("statAfterResetPush");
        popEntry("afterReset");

`ifdef MINER_SOLN_TIMESTAMP_EN
        // Push whose request cycle lands on counter value 100
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete(); modelOvf = 1'b0; modelIrqEn = 1'b0;
        for (int i = 0; i < 200 && tbCycles != 97; i++) @(negedge clk);
        checkOutput("tsAlign", 32'(tbCycles), 32'd97);
        applyStimulus(64'h0000_0064_0000_0064);
        busRead(3'd4, rd);
        checkOutput("ts100", rd, 32'd100);
        popEntry("tsEntry");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
